// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and helpers for the UART receive monitor.
// Error flag indices describe the two low bits of every buffered frame word.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int ERR_PARITY = 1;
  localparam int ERR_FRAME  = 0;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_rx_expect_if.sv
// Receive-FIFO head and expected-byte handshakes of the UART receive monitor.
// The monitor is the master; whoever pops frames and supplies expectations is the slave.
interface uart_rx_expect_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic [1:0]           rx_err;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] exp_data;
  logic                 exp_valid;
  logic                 exp_ready;

  modport master (
    output rx_data, rx_err, rx_valid, exp_ready,
    input  rx_ready, exp_data, exp_valid
  );

  modport slave (
    input  rx_data, rx_err, rx_valid, exp_ready,
    output rx_ready, exp_data, exp_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous first-word-fall-through FIFO; the head is visible whenever empty is low.
// A push into a full FIFO is only accepted if the head is popped in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit tells full from empty when the index bits coincide.
  always_comb begin
    empty   = (wptr == rptr);
    full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = empty ? '0 : mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_expect.sv
// UART receive monitor: samples frames, flags parity/framing errors, buffers them
// and scores each received word against an expected-byte stream.
module uart_rx_expect
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  uart_rx_expect_if.master bus,
  output logic             match_pulse,
  output logic             mismatch_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             overflow,
  output logic             busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int FW   = DATA_BITS + 2;

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_e            state;
  rx_state_e            state_nx;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 frm_err;
  logic                 tick;
  logic                 done;
  logic                 frm_now;
  logic                 hit;

  logic                 push_q;
  logic [FW-1:0]        push_word;
  logic [FW-1:0]        fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // The start bit is re-checked half a bit in; every later sample is one full bit apart.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    tick     = (state == ST_START) ? (cnt == CW'(HALF - 1)) : (cnt == CW'(CLKS_PER_BIT - 1));
    frm_now  = frm_err | ~rx_s;
    hit      = (shreg == bus.exp_data) && !par_err && !frm_now;
    unique case (state)
      ST_IDLE:      if (!rx_s) state_nx = ST_START;
      ST_START:     if (tick) state_nx = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (tick && bit_idx == 4'(DATA_BITS - 1))
          state_nx = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
      end
      ST_PAR:       if (tick) state_nx = ST_STOP;
      ST_STOP: begin
        if (tick && bit_idx == 4'(STOP_BITS - 1)) begin
          done     = 1'b1;
          state_nx = frm_now ? ST_WAIT_HIGH : ST_IDLE;
        end
      end
      ST_WAIT_HIGH: if (rx_s) state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      cnt <= (state_nx != state || tick) ? '0 : cnt + 1'b1;
      unique case (state)
        ST_IDLE: begin
          bit_idx <= '0;
          par_err <= 1'b0;
          frm_err <= 1'b0;
        end
        ST_DATA: begin
          if (tick) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= (bit_idx == 4'(DATA_BITS - 1)) ? '0 : bit_idx + 1'b1;
          end
        end
        ST_PAR: begin
          // Odd parity wants the XOR over data and parity bit to be 1, even wants 0.
          if (tick) par_err <= (^shreg) ^ rx_s ^ (PARITY == PARITY_ODD);
        end
        ST_STOP: begin
          if (tick) begin
            frm_err <= frm_now;
            bit_idx <= bit_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Completion is registered: push and score happen one cycle after the last stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_q         <= 1'b0;
      push_word      <= '0;
      bus.exp_ready  <= 1'b0;
      match_pulse    <= 1'b0;
      mismatch_pulse <= 1'b0;
    end else begin
      push_q         <= done;
      bus.exp_ready  <= done && bus.exp_valid;
      match_pulse    <= done && bus.exp_valid && hit;
      mismatch_pulse <= done && bus.exp_valid && !hit;
      if (done) begin
        push_word[FW-1:2]       <= shreg;
        push_word[ERR_PARITY]   <= par_err;
        push_word[ERR_FRAME]    <= frm_now;
      end
    end
  end

  assign fifo_pop = bus.rx_ready && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      overflow     <= 1'b0;
    end else begin
      if (match_pulse)    match_cnt    <= sat_inc(match_cnt);
      if (mismatch_pulse) mismatch_cnt <= sat_inc(mismatch_cnt);
      if (push_q && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata (push_word),
    .pop   (bus.rx_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.rx_valid = !fifo_empty;
  assign bus.rx_data  = fifo_rdata[FW-1:2];
  assign bus.rx_err   = fifo_rdata[1:0];
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_expect.sv
// Bench for uart_rx_expect: an 8N1 instance with a 4-deep FIFO and an 8E2 instance,
// checked against a frame-level model of buffered words, scores and counts.
module tb_uart_rx_expect;

  localparam int CPB    = 16;
  localparam int DEPTH0 = 4;
  localparam int DEPTH1 = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_v        [2];
  logic       rx_ready_v  [2];
  logic [7:0] exp_data_v  [2];
  logic       exp_valid_v [2];
  logic [7:0] rx_data_v   [2];
  logic [1:0] rx_err_v    [2];
  logic       rx_valid_v  [2];
  logic       exp_ready_v [2];
  logic       match_v     [2];
  logic       mismatch_v  [2];
  logic [15:0] mcnt_v     [2];
  logic [15:0] mmcnt_v    [2];
  logic       ovf_v       [2];
  logic       busy_v      [2];

  int nChecks = 0;
  int nFails  = 0;

  typedef struct { int dut; bit match; } ev_t;
  logic [9:0] mf [$];
  ev_t        evq [$];
  int         exp_m  [2];
  int         exp_mm [2];
  bit         ovf_m  [2];

  always #5 clk = ~clk;

  uart_rx_expect_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_expect_if #(.DATA_BITS(8)) bus1 ();

  assign bus0.rx_ready  = rx_ready_v[0];
  assign bus0.exp_data  = exp_data_v[0];
  assign bus0.exp_valid = exp_valid_v[0];
  assign rx_data_v[0]   = bus0.rx_data;
  assign rx_err_v[0]    = bus0.rx_err;
  assign rx_valid_v[0]  = bus0.rx_valid;
  assign exp_ready_v[0] = bus0.exp_ready;
  assign bus1.rx_ready  = rx_ready_v[1];
  assign bus1.exp_data  = exp_data_v[1];
  assign bus1.exp_valid = exp_valid_v[1];
  assign rx_data_v[1]   = bus1.rx_data;
  assign rx_err_v[1]    = bus1.rx_err;
  assign rx_valid_v[1]  = bus1.rx_valid;
  assign exp_ready_v[1] = bus1.exp_ready;

  uart_rx_expect #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (DEPTH0)
  ) dut0 (
    .clk (clk), .rst (rst), .rx (rx_v[0]), .bus (bus0),
    .match_pulse (match_v[0]), .mismatch_pulse (mismatch_v[0]),
    .match_cnt (mcnt_v[0]), .mismatch_cnt (mmcnt_v[0]),
    .overflow (ovf_v[0]), .busy (busy_v[0])
  );

  uart_rx_expect #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY (2), .STOP_BITS (2), .FIFO_DEPTH (DEPTH1)
  ) dut1 (
    .clk (clk), .rst (rst), .rx (rx_v[1]), .bus (bus1),
    .match_pulse (match_v[1]), .mismatch_pulse (mismatch_v[1]),
    .match_cnt (mcnt_v[1]), .mismatch_cnt (mmcnt_v[1]),
    .overflow (ovf_v[1]), .busy (busy_v[1])
  );

  function automatic void checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Frame-level model: what gets buffered, whether it scores, and the resulting counts.
  function automatic void modelFrame(input int d, input logic [7:0] data, input bit perr,
                                     input bit ferr, input bit use_exp, input logic [7:0] exp);
    int depth;
    bit m;
    depth = (d == 0) ? DEPTH0 : DEPTH1;
    if (mf.size() < depth) mf.push_back({data, perr, ferr});
    else                   ovf_m[d] = 1'b1;
    if (use_exp) begin
      m = (data == exp) && !perr && !ferr;
      evq.push_back('{dut: d, match: m});
      if (m) exp_m[d]++;
      else   exp_mm[d]++;
    end
  endfunction

  task automatic driveBit(input int d, input logic b);
    rx_v[d] = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic applyStimulus(input int d, input logic [7:0] data, input bit use_exp,
                               input logic [7:0] exp, input bit bad_par);
    bit has_par;
    int nstop;
    has_par = (d == 1);
    nstop   = (d == 1) ? 2 : 1;
    modelFrame(d, data, has_par && bad_par, 1'b0, use_exp, exp);
    exp_data_v[d]  = exp;
    exp_valid_v[d] = use_exp;
    driveBit(d, 1'b0);
    for (int i = 0; i < 8; i++) driveBit(d, data[i]);
    if (has_par) driveBit(d, (^data) ^ bad_par);
    for (int i = 0; i < nstop; i++) driveBit(d, 1'b1);
  endtask

  task automatic checkOutput(input int d, input string tag);
    checkVal({tag, "_match_cnt"},    mcnt_v[d],  exp_m[d]);
    checkVal({tag, "_mismatch_cnt"}, mmcnt_v[d], exp_mm[d]);
    checkVal({tag, "_overflow"},     ovf_v[d],   ovf_m[d]);
    checkVal({tag, "_busy"},         busy_v[d],  0);
    checkVal({tag, "_pending_evt"},  evq.size(), 0);
    checkVal({tag, "_rx_valid"},     rx_valid_v[d], mf.size() != 0);
    if (mf.size() != 0) begin
      checkVal({tag, "_head_data"}, rx_data_v[d], mf[0][9:2]);
      checkVal({tag, "_head_err"},  rx_err_v[d],  mf[0][1:0]);
    end
  endtask

  task automatic popFifo(input int d, input string tag);
    while (mf.size() > 0) begin
      checkVal({tag, "_pop_valid"}, rx_valid_v[d], 1);
      checkVal({tag, "_pop_data"},  rx_data_v[d],  mf[0][9:2]);
      checkVal({tag, "_pop_err"},   rx_err_v[d],   mf[0][1:0]);
      rx_ready_v[d] = 1'b1;
      @(negedge clk);
      rx_ready_v[d] = 1'b0;
      void'(mf.pop_front());
    end
    checkVal({tag, "_drained"}, rx_valid_v[d], 0);
  endtask

  // Every score pulse must correspond to the next modelled frame, on the right instance.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (match_v[d] || mismatch_v[d] || exp_ready_v[d]) begin
        ev_t e;
        if (evq.size() == 0 || evq[0].dut != d) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected_pulse dut%0d: match=%0b mismatch=%0b exp_ready=%0b, expected no pulse",
                   d, match_v[d], mismatch_v[d], exp_ready_v[d]);
        end else begin
          e = evq.pop_front();
          checkVal("pulse_exp_ready", exp_ready_v[d], 1);
          checkVal("pulse_match",     match_v[d],     e.match);
          checkVal("pulse_mismatch",  mismatch_v[d],  !e.match);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rx_v[d] = 1'b1;
      rx_ready_v[d] = 1'b0;
      exp_data_v[d] = 8'h00;
      exp_valid_v[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkVal("rst_busy",      busy_v[d],      0);
      checkVal("rst_rx_valid",  rx_valid_v[d],  0);
      checkVal("rst_rx_data",   rx_data_v[d],   0);
      checkVal("rst_rx_err",    rx_err_v[d],    0);
      checkVal("rst_match_cnt", mcnt_v[d],      0);
      checkVal("rst_mism_cnt",  mmcnt_v[d],     0);
      checkVal("rst_overflow",  ovf_v[d],       0);
      checkVal("rst_exp_ready", exp_ready_v[d], 0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] test 1: 0x37 against expected 0x37");
    applyStimulus(0, 8'h37, 1'b1, 8'h37, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput(0, "t1");
    checkVal("t1_data_lit", rx_data_v[0], 8'h37);
    checkVal("t1_cnt_lit",  mcnt_v[0],    1);

    $display("[TB] test 2: 0x37 against expected 0x38, then a frame with no expectation");
    applyStimulus(0, 8'h37, 1'b1, 8'h38, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput(0, "t2");
    checkVal("t2_mism_lit", mmcnt_v[0], 1);
    applyStimulus(0, 8'h55, 1'b0, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput(0, "t2_noexp");
    popFifo(0, "t2");

    $display("[TB] test 3: even parity, bad parity bit then good frame");
    applyStimulus(1, 8'hA5, 1'b1, 8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput(1, "t3");
    checkVal("t3_err_lit",  rx_err_v[1],  2'b10);
    checkVal("t3_data_lit", rx_data_v[1], 8'hA5);
    checkVal("t3_mism_lit", mmcnt_v[1],   1);
    applyStimulus(1, 8'h3C, 1'b1, 8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput(1, "t3_good");
    popFifo(1, "t3");

    $display("[TB] test 4: line held low for 20 bit times");
    exp_data_v[0]  = 8'h00;
    exp_valid_v[0] = 1'b1;
    modelFrame(0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00);
    rx_v[0] = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    checkVal("t4_busy_held", busy_v[0],   1);
    checkVal("t4_err_lit",   rx_err_v[0], 2'b01);
    rx_v[0] = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput(0, "t4");
    popFifo(0, "t4");

    $display("[TB] test 5: five frames into a 4-deep FIFO without popping");
    for (int i = 1; i <= 5; i++) applyStimulus(0, 8'(i), 1'b1, 8'(i), 1'b0);
    repeat (4) @(negedge clk);
    checkOutput(0, "t5");
    checkVal("t5_ovf_lit",  ovf_v[0],     1);
    checkVal("t5_head_lit", rx_data_v[0], 8'h01);
    checkVal("t5_cnt_lit",  mcnt_v[0],    6);

    $display("[TB] test 6: 4-cycle glitch, then reset mid-frame");
    rx_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx_v[0] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkOutput(0, "t6_glitch");
    rx_v[0] = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    checkVal("t6_busy_mid", busy_v[0], 1);
    rst = 1'b1;
    rx_v[0] = 1'b1;
    @(negedge clk);
    mf.delete();
    evq.delete();
    for (int d = 0; d < 2; d++) begin
      exp_m[d] = 0;
      exp_mm[d] = 0;
      ovf_m[d] = 1'b0;
    end
    checkVal("t6_rst_busy",     busy_v[0],     0);
    checkVal("t6_rst_rx_valid", rx_valid_v[0], 0);
    checkVal("t6_rst_cnt",      mcnt_v[0],     0);
    checkVal("t6_rst_ovf",      ovf_v[0],      0);
    rst = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    checkOutput(0, "t6_after0");
    checkOutput(1, "t6_after1");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
